// File: rtl/hc_mmio_initiator.sv
`timescale 1ns/1ps
// Host-side MMIO CSR requester: issues single-cycle write/read pulses, tracks reads by tid,
// and completes them from a matching response or with a synthetic all-ones timeout completion.
module hc_mmio_initiator #(
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned TID_W           = 9,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 256
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   cmd_valid,
   output logic                                   cmd_ready,
   input  logic                                   cmd_write,
   input  logic [ADDR_W-1:0]                      cmd_addr,
   input  logic [63:0]                            cmd_data,
   output logic                                   mmio_wr_valid,
   output logic                                   mmio_rd_valid,
   output logic [ADDR_W-1:0]                      mmio_addr,
   output logic [TID_W-1:0]                       mmio_tid,
   output logic [63:0]                            mmio_data,
   input  logic                                   rsp_valid,
   input  logic [TID_W-1:0]                       rsp_tid,
   input  logic [63:0]                            rsp_data,
   output logic                                   rd_valid,
   output logic [ADDR_W-1:0]                      rd_addr,
   output logic [63:0]                            rd_data,
   output logic                                   rd_timeout,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
   output logic                                   busy,
   output logic                                   err_unexpected
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef struct packed {
      logic              valid;
      logic [TID_W-1:0]  tid;
      logic [ADDR_W-1:0] addr;
      logic [AGE_W-1:0]  age;
   } entry_t;

   entry_t             r_tbl [MAX_OUTSTANDING];
   logic [TID_W-1:0]   r_tid;
   logic [CNT_W-1:0]   r_outstanding;
   logic               r_cmd_ready;
   logic               r_mmio_wr_valid;
   logic               r_mmio_rd_valid;
   logic [ADDR_W-1:0]  r_mmio_addr;
   logic [TID_W-1:0]   r_mmio_tid;
   logic [63:0]        r_mmio_data;
   logic               r_rd_valid;
   logic [ADDR_W-1:0]  r_rd_addr;
   logic [63:0]        r_rd_data;
   logic               r_rd_timeout;
   logic               r_busy;
   logic               r_err;

   entry_t             w_tbl_nxt [MAX_OUTSTANDING];
   logic [TID_W-1:0]   w_tid_nxt;
   logic [CNT_W-1:0]   w_out_nxt;
   logic               w_cmd_ready_nxt;
   logic               w_mmio_wr_valid_nxt;
   logic               w_mmio_rd_valid_nxt;
   logic [ADDR_W-1:0]  w_mmio_addr_nxt;
   logic [TID_W-1:0]   w_mmio_tid_nxt;
   logic [63:0]        w_mmio_data_nxt;
   logic               w_rd_valid_nxt;
   logic [ADDR_W-1:0]  w_rd_addr_nxt;
   logic [63:0]        w_rd_data_nxt;
   logic               w_rd_timeout_nxt;
   logic               w_busy_nxt;
   logic               w_err_nxt;

   logic               w_match_hit;
   logic [IDX_W-1:0]   w_match_idx;
   logic               w_exp_hit;
   logic [IDX_W-1:0]   w_exp_idx;
   logic               w_free_hit;
   logic [IDX_W-1:0]   w_free_idx;
   logic               w_accept;
   logic               w_accept_rd;
   logic               w_cpl_fire;
   logic [IDX_W-1:0]   w_cpl_idx;

   assign w_accept    = cmd_valid & r_cmd_ready;
   assign w_accept_rd = w_accept & ~cmd_write & w_free_hit;
   // A matching response always wins the single completion slot over an expired entry
   assign w_cpl_fire  = w_match_hit | w_exp_hit;
   assign w_cpl_idx   = w_match_hit ? w_match_idx : w_exp_idx;

   // Lowest-index search for response match, expired entry and free entry
   always_comb begin
      w_match_hit = 1'b0;
      w_match_idx = '0;
      w_exp_hit   = 1'b0;
      w_exp_idx   = '0;
      w_free_hit  = 1'b0;
      w_free_idx  = '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
         if (!w_match_hit && rsp_valid && r_tbl[i].valid && (r_tbl[i].tid == rsp_tid)) begin
            w_match_hit = 1'b1;
            w_match_idx = IDX_W'(i);
         end
         if (!w_exp_hit && r_tbl[i].valid && (r_tbl[i].age == AGE_MAX)) begin
            w_exp_hit = 1'b1;
            w_exp_idx = IDX_W'(i);
         end
         if (!w_free_hit && !r_tbl[i].valid) begin
            w_free_hit = 1'b1;
            w_free_idx = IDX_W'(i);
         end
      end
   end

   // Next-state for tracking table, request pulses and completions
   always_comb begin
      w_tbl_nxt           = r_tbl;
      w_tid_nxt           = r_tid;
      w_mmio_wr_valid_nxt = w_accept & cmd_write;
      w_mmio_rd_valid_nxt = w_accept_rd;
      w_mmio_addr_nxt     = r_mmio_addr;
      w_mmio_tid_nxt      = r_mmio_tid;
      w_mmio_data_nxt     = r_mmio_data;
      w_rd_valid_nxt      = w_cpl_fire;
      w_rd_timeout_nxt    = w_cpl_fire & ~w_match_hit;
      w_rd_addr_nxt       = r_rd_addr;
      w_rd_data_nxt       = r_rd_data;
      w_err_nxt           = r_err | (rsp_valid & ~w_match_hit);
      w_out_nxt           = r_outstanding + CNT_W'(w_accept_rd) - CNT_W'(w_cpl_fire);
      w_cmd_ready_nxt     = (w_out_nxt < MAX_CNT);
      w_busy_nxt          = (w_out_nxt != '0) | w_accept;

      // Ages saturate so a deferred expired entry stays expired until it gets the slot
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
         if (r_tbl[i].valid && (r_tbl[i].age != AGE_MAX)) begin
            w_tbl_nxt[i].age = r_tbl[i].age + AGE_W'(1);
         end
      end

      if (w_accept) begin
         w_tid_nxt       = r_tid + TID_W'(1);
         w_mmio_addr_nxt = cmd_addr;
         w_mmio_tid_nxt  = r_tid;
         w_mmio_data_nxt = cmd_write ? cmd_data : 64'd0;
      end

      if (w_cpl_fire) begin
         w_tbl_nxt[w_cpl_idx].valid = 1'b0;
         w_rd_addr_nxt              = r_tbl[w_cpl_idx].addr;
         w_rd_data_nxt              = w_match_hit ? rsp_data : {64{1'b1}};
      end

      // Freed entry is still valid this cycle, so the allocated slot is always distinct
      if (w_accept_rd) begin
         w_tbl_nxt[w_free_idx].valid = 1'b1;
         w_tbl_nxt[w_free_idx].tid   = r_tid;
         w_tbl_nxt[w_free_idx].addr  = cmd_addr;
         w_tbl_nxt[w_free_idx].age   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            r_tbl[i] <= '0;
         end
         r_tid           <= '0;
         r_outstanding   <= '0;
         r_cmd_ready     <= 1'b0;
         r_mmio_wr_valid <= 1'b0;
         r_mmio_rd_valid <= 1'b0;
         r_mmio_addr     <= '0;
         r_mmio_tid      <= '0;
         r_mmio_data     <= '0;
         r_rd_valid      <= 1'b0;
         r_rd_addr       <= '0;
         r_rd_data       <= '0;
         r_rd_timeout    <= 1'b0;
         r_busy          <= 1'b0;
         r_err           <= 1'b0;
      end else begin
         r_tbl           <= w_tbl_nxt;
         r_tid           <= w_tid_nxt;
         r_outstanding   <= w_out_nxt;
         r_cmd_ready     <= w_cmd_ready_nxt;
         r_mmio_wr_valid <= w_mmio_wr_valid_nxt;
         r_mmio_rd_valid <= w_mmio_rd_valid_nxt;
         r_mmio_addr     <= w_mmio_addr_nxt;
         r_mmio_tid      <= w_mmio_tid_nxt;
         r_mmio_data     <= w_mmio_data_nxt;
         r_rd_valid      <= w_rd_valid_nxt;
         r_rd_addr       <= w_rd_addr_nxt;
         r_rd_data       <= w_rd_data_nxt;
         r_rd_timeout    <= w_rd_timeout_nxt;
         r_busy          <= w_busy_nxt;
         r_err           <= w_err_nxt;
      end
   end

   assign cmd_ready      = r_cmd_ready;
   assign mmio_wr_valid  = r_mmio_wr_valid;
   assign mmio_rd_valid  = r_mmio_rd_valid;
   assign mmio_addr      = r_mmio_addr;
   assign mmio_tid       = r_mmio_tid;
   assign mmio_data      = r_mmio_data;
   assign rd_valid       = r_rd_valid;
   assign rd_addr        = r_rd_addr;
   assign rd_data        = r_rd_data;
   assign rd_timeout     = r_rd_timeout;
   assign outstanding    = r_outstanding;
   assign busy           = r_busy;
   assign err_unexpected = r_err;

endmodule
